cpu_vec: RTL and testbench
==========================

// Module: cpu_vec
// PURPOSE
//  Parametrised multicycle 16-bit-class CPU core with prioritised, vectored interrupts (NINT lines).
//  Same 4-bit-opcode ISA as the current core; adds reset, width/depth generics, NOP for unused
//  opcodes, interrupt id output and an internal vector-table fetch.
//  Sits between the single-port program/data memory and the board I/O (R4/R5 debug outputs).
// PARAMETERS
//  DW        16       data/register width; must be >= 16
//  AW        12       address/PC width; must be >= 12 and <= DW
//  NINT      3        number of interrupt request lines, 1..8
//  RESET_PC  0        PC value after reset
//  VEC_BASE  'hFF0    vector table base; vector of line k at VEC_BASE+k
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst_n     in   1      asynchronous active-low reset
//  irq       in   NINT   level interrupt requests; higher index = higher priority
//  datain    in   DW     memory read data (combinational read of address)
//  dataout   out  DW     memory write data
//  address   out  AW     memory address
//  memwrt    out  1      memory write strobe (write at end of cycle)
//  intack    out  1      one-cycle pulse in INT2
//  intid     out  3      index of interrupt being serviced, valid while intack=1
//  dbg_r4    out  DW     R4;  dbg_r5  out  DW  R5
// BEHAVIOUR
//  Regs R0..R7 (DW); R7=SP, R6=flags: bit0 Z, bit1 IE. Instr fields: op=datain[DW-1:DW-4],
//  ir=datain[11:0]; a=ir[8:6], b=ir[5:3], d=ir[2:0], aluop=ir[11:9]; off=ir sign-extended to AW.
//  Reset: state FETCH, pc=RESET_PC, R0..R6=0, R7=all-ones (AW bits, zero-extended), intid=0;
//   outputs: address=RESET_PC, memwrt=0, intack=0, dataout=0. Reset mid-instruction aborts it.
//  FETCH: address=pc; ir<=datain; pc<=pc+1; go to decoded state.
//  Opcodes: 1 LDI, 2 LD, 3 ST, 4 JZ, 5 JMP, 7 ALU, 8 PUSH, 9 POP1->POP2, A CALL, B RET1->RET2,
//   C CLI, D STI, E IRET->IRET2->IRET3; 0,6,F NOP (one execute cycle, no side effect).
//  LDI: address=pc, R[d]<=datain, pc<=pc+1.  LD: address=R[b][AW-1:0], R[d]<=datain.
//  ST: address=R[b], dataout=R[a], memwrt=1.  JZ: if Z pc<=pc+off.  JMP: pc<=pc+off (wraps mod 2^AW).
//  ALU: R[d]<=f(R[a],R[b]); Z<=(result==0). f: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT a,6 MOV a,7 a+1;
//   carry discarded. If d=6, Z update overrides result bit0.
//  PUSH: address=SP, dataout=R[a], memwrt=1, SP<=SP-1.  POP1: SP<=SP+1; POP2: address=SP, R[d]<=datain.
//  CALL: address=SP, dataout=pc (zero-ext), memwrt=1, SP<=SP-1, pc<=pc+off.
//  RET1: SP<=SP+1; RET2: address=SP, pc<=datain[AW-1:0].  CLI/STI: IE<=0/1.
//  IRET: SP<=SP+1; IRET2: address=SP, pc<=datain, SP<=SP+1; IRET3: address=SP, R6<=datain.
//  Interrupt check on the last cycle of every instruction except CLI, STI, IRET3: if IE & |irq ->
//   INT (latch intid = highest set index), else FETCH. Interrupts never split multi-cycle instrs.
//  INT: address=SP, dataout=R6, memwrt=1, SP--.  INT1: address=SP, dataout=pc, memwrt=1, SP--, IE<=0.
//  INT2: address=VEC_BASE+intid, intack=1, pc<=datain[AW-1:0]; -> FETCH.
//  Stack wraps modulo 2^AW; no overflow detection. memwrt=0 and dataout holds 0 in non-write states.
//  SP/addresses use R[x][AW-1:0]; upper DW-AW bits ignored on address, preserved in registers.
// TESTING
//  LDI R1,5; LDI R2,5; ALU SUB R1,R2->R3; JZ +2 -> R3=0, Z=1, branch taken, pc skips 2 words.
//  PUSH R1 with SP=0xFFF -> write 5 at 0xFFF, SP=0xFFE; POP R4 -> R4=5, dbg_r4=5, SP=0xFFF.
//  CALL +0x10 at pc=0x020 -> mem[SP]=0x021, pc=0x031; RET -> pc=0x021, SP restored.
//  STI, irq=3'b101 during LD -> LD completes, intid=2, mem stack gets R6 then pc, IE=0,
//   pc=mem[VEC_BASE+2]; IRET -> pc and R6 (IE=1) restored.
//  IE=0 with irq held -> no INT entry; CLI followed by irq asserted same cycle -> not taken.
//  Assert rst_n low in INT1 -> state FETCH, pc=RESET_PC, SP=0xFFF, memwrt=0 immediately (async).

Source files
------------

// File: rtl/cpu_vec_if.sv
// cpu_vec_if: memory, interrupt and debug bus between cpu_vec and its board
interface cpu_vec_if #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int NINT = 3
);
  logic [NINT-1:0] irq;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataout;
  logic [AW-1:0] address;
  logic memwrt;
  logic intack;
  logic [2:0] intid;
  logic [DW-1:0] dbg_r4;
  logic [DW-1:0] dbg_r5;
  modport master (
    input irq, datain,
    output dataout, address, memwrt, intack, intid, dbg_r4, dbg_r5
  );
  modport slave (
    output irq, datain,
    input dataout, address, memwrt, intack, intid, dbg_r4, dbg_r5
  );
endinterface

// File: rtl/cpu_vec.sv
// cpu_vec: multicycle CPU core with prioritised, vectored interrupts
module cpu_vec #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int NINT = 3,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] VEC_BASE = 'hFF0
) (
  input logic clk,
  input logic rst_n,
  cpu_vec_if.master bus
);
  typedef enum logic [4:0] {
    S_FETCH, S_LDI, S_LD, S_ST, S_JZ, S_JMP, S_ALU, S_NOP, S_PUSH, S_POP1, S_POP2,
    S_CALL, S_RET1, S_RET2, S_CLI, S_STI, S_IRET, S_IRET2, S_IRET3, S_INT, S_INT1, S_INT2
  } state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_pc, w_sp, w_off, w_vec;
  logic [11:0] r_ir;
  logic [DW-1:0] r_regs [8];
  logic [2:0] r_intid, w_hi, w_a, w_b, w_d;
  logic [DW-1:0] w_ra, w_rb, w_alu;
  logic w_end, w_ie, w_z;
  assign w_a = r_ir[8:6];
  assign w_b = r_ir[5:3];
  assign w_d = r_ir[2:0];
  assign w_ra = r_regs[w_a];
  assign w_rb = r_regs[w_b];
  assign w_sp = r_regs[7][AW-1:0];
  assign w_ie = r_regs[6][1];
  assign w_z = r_regs[6][0];
  assign w_off = AW'($signed(r_ir));
  assign w_vec = VEC_BASE + AW'(r_intid);
  assign bus.intid = r_intid;
  assign bus.dbg_r4 = r_regs[4];
  assign bus.dbg_r5 = r_regs[5];
  // highest-index pending request wins
  always_comb begin
    w_hi = '0;
    for (int k = 0; k < NINT; k++) if (bus.irq[k]) w_hi = 3'(k);
  end
  // ALU function select; carry is discarded
  always_comb
    case (r_ir[11:9])
      3'd0: w_alu = w_ra + w_rb;
      3'd1: w_alu = w_ra - w_rb;
      3'd2: w_alu = w_ra & w_rb;
      3'd3: w_alu = w_ra | w_rb;
      3'd4: w_alu = w_ra ^ w_rb;
      3'd5: w_alu = ~w_ra;
      3'd6: w_alu = w_ra;
      default: w_alu = w_ra + 1'b1;
    endcase
  // next state and bus outputs; w_end marks an instruction's final cycle, where interrupts are sampled
  always_comb begin
    w_next = S_FETCH;
    w_end = 1'b0;
    bus.address = r_pc;
    bus.dataout = '0;
    bus.memwrt = 1'b0;
    bus.intack = 1'b0;
    case (r_state)
      S_FETCH:
        case (bus.datain[DW-1:DW-4])
          4'h1: w_next = S_LDI;
          4'h2: w_next = S_LD;
          4'h3: w_next = S_ST;
          4'h4: w_next = S_JZ;
          4'h5: w_next = S_JMP;
          4'h7: w_next = S_ALU;
          4'h8: w_next = S_PUSH;
          4'h9: w_next = S_POP1;
          4'hA: w_next = S_CALL;
          4'hB: w_next = S_RET1;
          4'hC: w_next = S_CLI;
          4'hD: w_next = S_STI;
          4'hE: w_next = S_IRET;
          default: w_next = S_NOP;
        endcase
      S_LDI, S_JZ, S_JMP, S_ALU, S_NOP: w_end = 1'b1;
      S_LD: begin
        bus.address = w_rb[AW-1:0];
        w_end = 1'b1;
      end
      S_ST: begin
        bus.address = w_rb[AW-1:0];
        bus.dataout = w_ra;
        bus.memwrt = 1'b1;
        w_end = 1'b1;
      end
      S_PUSH: begin
        bus.address = w_sp;
        bus.dataout = w_ra;
        bus.memwrt = 1'b1;
        w_end = 1'b1;
      end
      S_POP1: w_next = S_POP2;
      S_POP2, S_RET2: begin
        bus.address = w_sp;
        w_end = 1'b1;
      end
      S_CALL: begin
        bus.address = w_sp;
        bus.dataout = DW'(r_pc);
        bus.memwrt = 1'b1;
        w_end = 1'b1;
      end
      S_RET1: w_next = S_RET2;
      S_IRET: w_next = S_IRET2;
      S_IRET2: begin
        bus.address = w_sp;
        w_next = S_IRET3;
      end
      S_IRET3: bus.address = w_sp;
      S_INT: begin
        bus.address = w_sp;
        bus.dataout = r_regs[6];
        bus.memwrt = 1'b1;
        w_next = S_INT1;
      end
      S_INT1: begin
        bus.address = w_sp;
        bus.dataout = DW'(r_pc);
        bus.memwrt = 1'b1;
        w_next = S_INT2;
      end
      S_INT2: begin
        bus.address = w_vec;
        bus.intack = 1'b1;
      end
      default: ;
    endcase
    if (w_end && w_ie && |bus.irq) w_next = S_INT;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FETCH;
    else r_state <= w_next;
  // datapath: pc, instruction, register file and interrupt id
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_intid <= '0;
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
      r_regs[7] <= DW'({AW{1'b1}});
    end else begin
      if (w_next == S_INT) r_intid <= w_hi;
      case (r_state)
        S_FETCH: begin
          r_ir <= bus.datain[11:0];
          r_pc <= r_pc + 1'b1;
        end
        S_LDI: begin
          r_regs[w_d] <= bus.datain;
          r_pc <= r_pc + 1'b1;
        end
        S_LD, S_POP2: r_regs[w_d] <= bus.datain;
        S_JZ: if (w_z) r_pc <= r_pc + w_off;
        S_JMP: r_pc <= r_pc + w_off;
        S_ALU: begin
          r_regs[w_d] <= w_alu;
          r_regs[6][0] <= ~|w_alu;
        end
        S_PUSH, S_INT: r_regs[7][AW-1:0] <= w_sp - 1'b1;
        S_POP1, S_RET1, S_IRET: r_regs[7][AW-1:0] <= w_sp + 1'b1;
        S_CALL: begin
          r_regs[7][AW-1:0] <= w_sp - 1'b1;
          r_pc <= r_pc + w_off;
        end
        S_RET2, S_INT2: r_pc <= bus.datain[AW-1:0];
        S_CLI: r_regs[6][1] <= 1'b0;
        S_STI: r_regs[6][1] <= 1'b1;
        S_IRET2: begin
          r_pc <= bus.datain[AW-1:0];
          r_regs[7][AW-1:0] <= w_sp + 1'b1;
        end
        S_IRET3: r_regs[6] <= bus.datain;
        S_INT1: begin
          r_regs[7][AW-1:0] <= w_sp - 1'b1;
          r_regs[6][1] <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cpu_vec.sv
// tb_cpu_vec: program-driven scoreboard bench for cpu_vec
module tb_cpu_vec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit [15:0] mem [4096];
  logic ld_en = 1'b0;
  logic [11:0] ld_a = '0;
  logic [15:0] ld_d = '0;
  int checks = 0;
  int failures = 0;
  int p = 0;
  int n;
  logic [27:0] wr_q [$];
  logic [2:0] ack_q [$];
  int alu_exp [8] = '{'h1002, 'hF1E4, 'h0003, 'h0FFF, 'h0FFC, 'hFF0C, 'h00F3, 'h00F4};
  cpu_vec_if #(.DW(16), .AW(12), .NINT(3)) bus ();
  cpu_vec #(.DW(16), .AW(12), .NINT(3), .RESET_PC(12'h000), .VEC_BASE(12'hFF0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.datain = mem[bus.address];
  always @(posedge clk)
    if (ld_en) mem[ld_a] <= ld_d;
    else if (bus.memwrt) mem[bus.address] <= bus.dataout;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int ins(input int op, input int f, input int a, input int b, input int d);
    return int'({4'(op), 3'(f), 3'(a), 3'(b), 3'(d)});
  endfunction
  function automatic int jo(input int op, input int o);
    return int'({4'(op), 12'(o)});
  endfunction
  task automatic put(input int w);
    ld_a = 12'(p);
    ld_d = 16'(w);
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
    p++;
  endtask
  task automatic ew(input int a, input int d);
    wr_q.push_back({12'(a), 16'(d)});
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (bus.memwrt) begin
        if (wr_q.size() == 0) chk("wr_pending", 32'(wr_q.size()), 1);
        else chk("mem_wr", {4'h0, bus.address, bus.dataout}, {4'h0, wr_q.pop_front()});
      end
      if (bus.intack) begin
        if (ack_q.size() == 0) chk("ack_pending", 32'(ack_q.size()), 1);
        else chk("intid", 32'(bus.intid), 32'(ack_q.pop_front()));
      end
    end
  initial begin
    bus.irq = '0;
    #1;
    chk("rst_addr", 32'(bus.address), 0);
    chk("rst_memwrt", 32'(bus.memwrt), 0);
    chk("rst_intack", 32'(bus.intack), 0);
    chk("rst_dataout", 32'(bus.dataout), 0);
    chk("rst_intid", 32'(bus.intid), 0);
    chk("rst_r4", 32'(bus.dbg_r4), 0);
    chk("rst_r5", 32'(bus.dbg_r5), 0);
    put(ins(1, 0, 0, 0, 1)); put(5); put(ins(1, 0, 0, 0, 2)); put(5);
    put(ins(7, 1, 1, 2, 3)); put(jo(4, 2));
    put(ins(3, 0, 1, 0, 0)); put(ins(3, 0, 1, 0, 0));
    put(ins(1, 0, 0, 0, 0)); put('h0100);
    put(ins(3, 0, 3, 0, 0)); ew('h100, 0);
    put(ins(3, 0, 6, 0, 0)); ew('h100, 1);
    put(ins(8, 0, 1, 0, 0)); ew('hFFF, 5);
    put(ins(9, 0, 0, 0, 4));
    put(ins(8, 0, 7, 0, 0)); ew('hFFF, 'h0FFF);
    put(ins(9, 0, 0, 0, 7));
    put(ins(3, 0, 4, 0, 0)); ew('h100, 5);
    put(jo(5, 'h00E));
    p = 'h20;
    put(jo('hA, 'h010)); ew('hFFF, 'h0021);
    put(ins(3, 0, 7, 0, 0)); ew('h100, 'h0FFF);
    put(jo(5, 'h01D));
    p = 'h31;
    put(ins('hB, 0, 0, 0, 0));
    p = 'h40;
    put(ins('hD, 0, 0, 0, 0)); put(ins('hC, 0, 0, 0, 0));
    put(ins(3, 0, 6, 0, 0)); ew('h100, 1);
    put(ins(1, 0, 0, 0, 5)); put('h1234);
    put(ins('hD, 0, 0, 0, 0)); put(ins(2, 0, 0, 0, 4));
    ew('hFFF, 3); ew('hFFE, 'h0047);
    p = 'hFF2;
    put('h0080);
    p = 'h80;
    put(ins(3, 0, 4, 0, 0)); ew('h100, 1);
    put(ins(3, 0, 6, 0, 0)); ew('h100, 1);
    put(ins('hE, 0, 0, 0, 0));
    p = 'h47;
    put(ins(3, 0, 6, 0, 0)); ew('h100, 3);
    put(ins(3, 0, 7, 0, 0)); ew('h100, 'h0FFF);
    put(ins(1, 0, 0, 0, 1)); put('h00F3); put(ins(1, 0, 0, 0, 2)); put('h0F0F);
    for (int i = 0; i < 8; i++) begin
      put(ins(7, i, 1, 2, 3)); put(ins(3, 0, 3, 0, 0)); ew('h100, alu_exp[i]);
    end
    put(ins(7, 6, 2, 0, 6)); put(ins(3, 0, 6, 0, 0)); ew('h100, 'h0F0E);
    put(jo(4, 1)); put(ins(3, 0, 1, 0, 0)); ew('h100, 'h00F3);
    put(ins(1, 0, 0, 0, 0)); put('h01FF); put(ins(1, 0, 0, 0, 3)); put('hDEAD);
    put(ins(3, 0, 3, 0, 0)); ew('h1FF, 'hDEAD);
    put(jo(5, 'hFFF));
    bus.irq = 3'b101;
    ack_q.push_back(3'd2);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.intack && n < 500);
    chk("intack_seen", 32'(bus.intack), 1);
    bus.irq = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.memwrt && bus.address == 12'h1FF) && n < 1000);
    chk("marker_seen", 32'(bus.address), 'h1FF);
    chk("dbg_r4", 32'(bus.dbg_r4), 1);
    chk("dbg_r5", 32'(bus.dbg_r5), 'h1234);
    bus.irq = 3'b001;
    ew('hFFF, 'h0F0E);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.memwrt && n < 50);
    chk("int_wr_seen", 32'(bus.memwrt), 1);
    @(posedge clk);
    #1;
    chk("int1_memwrt", 32'(bus.memwrt), 1);
    chk("int1_addr", 32'(bus.address), 'hFFE);
    chk("int1_pc", 32'(bus.dataout), 'h0066);
    rst_n = 1'b0;
    #1;
    chk("arst_memwrt", 32'(bus.memwrt), 0);
    chk("arst_addr", 32'(bus.address), 0);
    chk("arst_dataout", 32'(bus.dataout), 0);
    chk("arst_intack", 32'(bus.intack), 0);
    bus.irq = '0;
    p = 0;
    put(ins(8, 0, 7, 0, 0)); ew('hFFF, 'h0FFF);
    put(ins(3, 0, 1, 0, 0)); ew(0, 0);
    put(jo(5, 'hFFF));
    chk("arst_r4", 32'(bus.dbg_r4), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("ack_q_empty", 32'(ack_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
